// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one registered-read RAM; write acks 2 cycles and read acks 3 cycles after the grant edge, with one IDLE cycle between grants.
// Port 0 has fixed priority by default; define ARB_ROUND_ROBIN_EN to alternate grants when both ports request.
module ram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0,
  input  logic                  i_req1,
  input  logic                  i_we0,
  input  logic                  i_we1,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_wdata0,
  input  logic [DATA_WIDTH-1:0] i_wdata1,
  output logic                  o_ack0,
  output logic                  o_ack1,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_data,
  output logic                  o_busy,
  output logic                  o_owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

  state_t state_q, state_d;
  logic   we_q;
  logic   gnt_vld;
  logic   gnt_sel;

  assign gnt_vld = i_req0 | i_req1;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;

  // On contention grant the port that did not win last time.
  assign gnt_sel = (i_req0 & i_req1) ? ~last_q : i_req1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_q <= 1'b1;
    end else if (state_q == IDLE && gnt_vld) begin
      last_q <= gnt_sel;
    end
  end
`else
  assign gnt_sel = ~i_req0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    o_busy   = 1'b0;
    o_ram_we = 1'b0;
    o_ack0   = 1'b0;
    o_ack1   = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) state_d = ISSUE;
      end
      ISSUE: begin
        o_busy   = 1'b1;
        o_ram_we = we_q;
        state_d  = we_q ? ACK : CAPTURE;
      end
      CAPTURE: begin
        o_busy  = 1'b1;
        state_d = ACK;
      end
      ACK: begin
        o_busy  = 1'b1;
        o_ack0  = ~o_owner;
        o_ack1  = o_owner;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The RAM address/data registers double as the latched request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_owner    <= 1'b0;
      we_q       <= 1'b0;
      o_ram_addr <= '0;
      o_ram_data <= '0;
      o_rdata0   <= '0;
      o_rdata1   <= '0;
    end else begin
      if (state_q == IDLE && gnt_vld) begin
        o_owner    <= gnt_sel;
        we_q       <= gnt_sel ? i_we1 : i_we0;
        o_ram_addr <= gnt_sel ? i_addr1 : i_addr0;
        o_ram_data <= gnt_sel ? i_wdata1 : i_wdata0;
      end
      if (state_q == CAPTURE) begin
        if (o_owner) o_rdata1 <= i_ram_data;
        else         o_rdata0 <= i_ram_data;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, transaction-level expectation model checked every cycle, plus directed scenarios.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [7:0]  addr0 = 0, addr1 = 0;
  logic [31:0] wdata0 = 0, wdata1 = 0;
  logic        ack0, ack1, ram_we, busy, owner;
  logic [31:0] rdata0, rdata1, ram_data, ram_rdata;
  logic [7:0]  ram_addr;

  int tests = 0;
  int fails = 0;
  bit done  = 0;

  ram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_ack0(ack0), .o_ack1(ack1), .o_rdata0(rdata0), .o_rdata1(rdata1),
    .o_ram_addr(ram_addr), .o_ram_data(ram_data), .o_ram_we(ram_we),
    .i_ram_data(ram_rdata), .o_busy(busy), .o_owner(owner)
  );

  always #5 clk = ~clk;

  // Behavioural RAM with registered read
  logic [31:0] ram [64];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr[7:2]] <= ram_data;
    ram_rdata <= ram[ram_addr[7:2]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a grant at edge g gives ISSUE in cycle 0, ack in cycle L-1, IDLE in cycle L.
  int          cyc, g, d, mlen;
  bit          m_act, was_act, t_port, t_we, m_last, m_owner, p;
  logic [7:0]  t_addr, m_raddr;
  logic [31:0] m_rdat, m_rd0, m_rd1;
  logic [31:0] mm [64];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; g = 0; m_act = 0; t_port = 0; t_we = 0; m_last = 1; m_owner = 0;
      t_addr = 0; m_raddr = 0; m_rdat = 0; m_rd0 = 0; m_rd1 = 0;
    end else begin
      was_act = m_act;
      cyc++;
      if (m_act) begin
        d    = cyc - g;
        mlen = t_we ? 2 : 3;
        if (t_we && d == 1) mm[t_addr[7:2]] = m_rdat;
        if (!t_we && d == 2) begin
          if (t_port) m_rd1 = mm[t_addr[7:2]];
          else        m_rd0 = mm[t_addr[7:2]];
        end
        if (d == mlen) m_act = 0;
      end
      if (!was_act && (req0 || req1)) begin
`ifdef ARB_ROUND_ROBIN_EN
        p = (req0 && req1) ? !m_last : req1;
`else
        p = !req0;
`endif
        m_act   = 1; g = cyc; t_port = p;
        t_we    = p ? we1 : we0;
        t_addr  = p ? addr1 : addr0;
        m_rdat  = p ? wdata1 : wdata0;
        m_owner = p; m_raddr = t_addr; m_last = p;
      end
    end
  end

  int cd, cl;
  always @(posedge clk) begin
    #2;
    if (!done) begin
      cd = cyc - g;
      cl = t_we ? 2 : 3;
      chk("busy", busy, m_act);
      chk("owner", owner, m_owner);
      chk("ack0", ack0, m_act && cd == cl - 1 && !t_port);
      chk("ack1", ack1, m_act && cd == cl - 1 && t_port);
      chk("ram_we", ram_we, m_act && cd == 0 && t_we);
      chk("ram_addr", ram_addr, m_raddr);
      chk("ram_data", ram_data, m_rdat);
      chk("rdata0", rdata0, m_rd0);
      chk("rdata1", rdata1, m_rd1);
      chk("ack_exclusive", ack0 & ack1, 0);
      chk("we_implies_busy", ram_we & ~busy, 0);
    end
  end

  // Single-port transaction; reports cycles to ack and number of RAM write cycles.
  task automatic txn(input bit pt, input bit w, input logic [7:0] a, input logic [31:0] wd,
                     input bit scramble, output int lat, output int wecnt);
    @(negedge clk);
    if (pt) begin req1 = 1; we1 = w; addr1 = a; wdata1 = wd; end
    else    begin req0 = 1; we0 = w; addr0 = a; wdata0 = wd; end
    @(posedge clk);
    @(negedge clk);
    req0 = 0; req1 = 0;
    if (scramble) begin addr0 = 8'h00; addr1 = 8'h00; wdata0 = 0; we0 = ~w; end
    lat = 0; wecnt = 0;
    for (int k = 1; k <= 10; k++) begin
      if (ram_we) wecnt++;
      if ((pt ? ack1 : ack0) === 1'b1) begin lat = k; break; end
      @(negedge clk);
    end
  endtask

  int lat, wc, nack, nack1;
  logic [3:0] seq;
  logic [3:0] seq_exp;

  initial begin
    for (int i = 0; i < 64; i++) begin ram[i] = 0; mm[i] = 0; end
    rst = 1;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_owner", owner, 0);
    chk("reset_rdata0", rdata0, 0);
    rst = 0;

    txn(0, 1, 8'h20, 32'hDEADBEEF, 0, lat, wc);
    chk("wr_latency", lat, 2);
    chk("wr_we_cycles", wc, 1);
    txn(0, 0, 8'h20, 32'h0, 0, lat, wc);
    chk("rd_latency", lat, 3);
    chk("rd_we_cycles", wc, 0);
    chk("rd_data0", rdata0, 32'hDEADBEEF);

    txn(1, 1, 8'h24, 32'h12345678, 0, lat, wc);
    txn(1, 0, 8'h24, 32'h0, 0, lat, wc);
    chk("p1_rd_latency", lat, 3);
    chk("p1_owner", owner, 1);
    chk("p1_rdata1", rdata1, 32'h12345678);
    chk("p1_rdata0_held", rdata0, 32'hDEADBEEF);

    txn(0, 1, 8'h28, 32'hA5A5A5A5, 1, lat, wc);
    chk("ignore_change_latency", lat, 2);
    @(negedge clk);
    chk("ignore_change_mem28", ram[10], 32'hA5A5A5A5);
    chk("ignore_change_mem00", ram[0], 32'h0);

    // Reset during CAPTURE of a port-1 read
    req1 = 1; we1 = 0; addr1 = 8'h24;
    @(posedge clk);
    @(negedge clk); req1 = 0;
    @(negedge clk); rst = 1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_outputs", {ack0, ack1, ram_we, owner}, 0);
    chk("rst_rdata", rdata0 | rdata1, 0);
    chk("rst_ram_bus", {ram_addr, 24'h0} | ram_data, 0);
    @(negedge clk);
    chk("rst_no_ack", ack0 | ack1, 0);
    rst = 0;

    // Both ports read continuously
    req0 = 1; we0 = 0; addr0 = 8'h20;
    req1 = 1; we1 = 0; addr1 = 8'h24;
    nack = 0; nack1 = 0; seq = 0;
    for (int k = 0; k < 40 && nack < 4; k++) begin
      @(negedge clk);
      if (ack1) nack1++;
      if (ack0 || ack1) begin seq[nack] = ack1; nack++; end
    end
    req0 = 0; req1 = 0;
    chk("contend_acks", nack, 4);
`ifdef ARB_ROUND_ROBIN_EN
    seq_exp = 4'b1010;
`else
    seq_exp = 4'b0000;
    chk("fixed_no_ack1", nack1, 0);
`endif
    chk("contend_sequence", seq, seq_exp);
    repeat (4) @(negedge clk);

    // Reset during ISSUE of a write: RAM write enable drops at once
    req0 = 1; we0 = 1; addr0 = 8'h30; wdata0 = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    chk("issue_we_high", ram_we, 1);
    rst = 1;
    #1;
    chk("issue_we_dropped", ram_we, 0);
    @(negedge clk);
    rst = 0; req0 = 0;
    @(negedge clk);
    chk("aborted_write_absent", ram[12], 0);

    // Random traffic, checked by the model every cycle
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      req0   = ($urandom_range(0, 2) != 0);
      req1   = ($urandom_range(0, 2) != 0);
      we0    = $urandom_range(0, 1);
      we1    = $urandom_range(0, 1);
      addr0  = {$urandom_range(0, 15), 2'b00};
      addr1  = {$urandom_range(0, 15), 2'b00};
      wdata0 = $urandom;
      wdata1 = $urandom;
    end
    req0 = 0; req1 = 0;
    repeat (6) @(negedge clk);
    done = 1;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data bus width of both requesters and the RAM.
REQ-002 Parameter ADDR_WIDTH, default 8: byte-address width; the arbiter passes it unshifted, and the RAM performs word indexing.
REQ-003 i_clk  input  1  single clock; all state changes on the rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_req0 / i_req1  input  1  access request from port 0 (CPU load/store) and port 1 (loader/debug).
REQ-006 i_we0 / i_we1  input  1  1 = write, 0 = read, per port.
REQ-007 i_addr0 / i_addr1  input  ADDR_WIDTH  byte address, per port.
REQ-008 i_wdata0 / i_wdata1  input  DATA_WIDTH  write data, per port.
REQ-009 o_ack0 / o_ack1  output  1  one-cycle completion pulse, per port.
REQ-010 o_rdata0 / o_rdata1  output  DATA_WIDTH  registered read data, per port; holds its value until that port's next read completes.
REQ-011 o_ram_addr  output  ADDR_WIDTH; o_ram_data  output  DATA_WIDTH; o_ram_we  output  1: drive the RAM.
REQ-012 i_ram_data  input  DATA_WIDTH  RAM registered read data; valid the cycle after the address edge.
REQ-013 o_busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 o_owner  output  1  index of the current or last granted port.

Function
REQ-015 FSM states: IDLE, ISSUE, CAPTURE, ACK; all outputs are registered or decoded from state only, with no combinational path from inputs to outputs.
REQ-016 IDLE: at the edge where any i_reqN=1, latch the winner's addr, wdata and we, set o_owner to the winner, and go to ISSUE; otherwise remain in IDLE.
REQ-017 ISSUE: o_ram_addr and o_ram_data come from the latched values; o_ram_we=1 only if the latched we=1, and only in this state; next state is CAPTURE for a read or ACK for a write.
REQ-018 CAPTURE: at the closing edge, register i_ram_data into o_rdata of the owner, then go to ACK.
REQ-019 ACK: o_ack of the owner is 1 for exactly one cycle; next state is IDLE.
REQ-020 Latency from the sampling edge to o_ack high: write, 2 cycles; read, 3 cycles.
REQ-021 Once granted, a transaction always completes; deassertion of req, or changes to addr, data or we after the grant, are ignored.
REQ-022 A requester holding req high through ACK starts a new transaction at the next IDLE edge; there are no back-to-back grants without an intervening IDLE cycle.
REQ-023 Outside ISSUE, o_ram_we=0, and o_ram_addr and o_ram_data hold their last value.
REQ-024 o_ack0 and o_ack1 are never high in the same cycle.
REQ-025 The RAM is never written by a port that has not been granted.

Reset
REQ-026 When i_rst=1, the FSM goes to IDLE asynchronously.
REQ-027 During reset, all outputs are 0: o_ackN, o_rdataN, o_ram_addr, o_ram_data, o_ram_we, o_busy and o_owner.
REQ-028 During reset, the round-robin pointer is set to "last granted = 1".
REQ-029 Reset asserted mid-transaction aborts it: no ack is issued, and o_ram_we drops immediately.

Configuration
REQ-030 Macro ARB_ROUND_ROBIN_EN defined: when both ports request in IDLE, grant the port not granted last; the pointer updates on every grant.
REQ-031 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, port 0 always wins; the pointer logic is absent.
REQ-032 In both configurations, a lone requester is granted immediately.

Verification
REQ-033 Port 0 write addr 0x20 data 0xDEADBEEF, then port 0 read 0x20 -> o_ram_we high in one cycle only; write ack 2 cycles after sampling; read ack at 3 cycles with o_rdata0=0xDEADBEEF.
REQ-034 Both ports request reads continuously with the macro defined -> grants alternate 0,1,0,1; with the macro undefined, port 1 is never acked while i_req0 stays high.
REQ-035 Port 1 read 0x24 while port 0 is idle -> o_owner=1, o_ack1 pulse, o_rdata0 unchanged.
REQ-036 Port 0 drops req and changes addr to 0x00 one cycle after grant of a write to 0x28 -> the write still lands at 0x28, and ack is issued.
REQ-037 i_rst pulsed during CAPTURE -> no ack, all outputs 0, and the next request with both ports active grants port 0.
REQ-038 Assertions over random traffic -> o_ack0 & o_ack1 never both high; o_ram_we only in ISSUE; o_busy equals (state != IDLE).
